// File: rtl/tau_pkg.sv
// Shared definitions for the status-flag path: flag bit positions inside the
// 8-bit flags word, the ALU operation class encoding and the flags width.
// decision_unit and its benches use the same bit positions.
package tau_pkg;

   localparam int FLAGS_WIDTH   = 8;

   // Bit positions inside the flags word; bits 3:0 are always zero.
   localparam int FLAG_ZERO     = 7;
   localparam int FLAG_SIGN     = 6;
   localparam int FLAG_CARRY    = 5;
   localparam int FLAG_OVERFLOW = 4;

   // Only the upper nibble carries state, so the shadow stack stores just that.
   localparam int FLAG_STORED_BITS = 4;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'd0,
      ALU_SUB   = 2'd1,
      ALU_LOGIC = 2'd2,
      ALU_SHIFT = 2'd3
   } alu_class_e;

endpackage

// File: rtl/flags_stack.sv
// flags_stack: small parameterised LIFO that shadows the flags register across
// call/interrupt entry and exit. Supports push, pop and a same-cycle swap
// (push+pop on a non-empty stack). Push-when-full and pop-when-empty are ignored
// and raise a sticky error. Only instantiated when FLAGS_SHADOW_STACK_EN is
// defined.
module flags_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top_data,
   output logic             pop_taken,
   output logic             full,
   output logic             empty,
   output logic             error
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic [IW-1:0]    top_idx;
   logic [IW-1:0]    push_idx;
   logic             do_push;
   logic             do_pop;
   logic             do_swap;
   logic             err_now;

   assign top_idx  = IW'(count - CW'(1));
   assign push_idx = IW'(count);
   assign top_data = mem[top_idx];

   // Decode the requested operation against the current occupancy.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      do_push    = 1'b0;
      do_pop     = 1'b0;
      do_swap    = 1'b0;
      err_now    = 1'b0;
      count_next = count;
      if (push && pop) begin
         // A swap on an empty stack degenerates into an error pop.
         if (empty) err_now = 1'b1;
         else       do_swap = 1'b1;
      end else if (push) begin
         if (full) err_now = 1'b1;
         else      do_push = 1'b1;
      end else if (pop) begin
         if (empty) err_now = 1'b1;
         else       do_pop  = 1'b1;
      end
      if (do_push)     count_next = count + CW'(1);
      else if (do_pop) count_next = count - CW'(1);
   end

   // Tells the flags register to load the old top (plain pop or swap).
   assign pop_taken = pop && !empty;

   // Entry storage: written on push into the next free slot, or over the top on swap.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; occupancy is tracked by count,
      // so stale entries are never visible and resetting them would only cost logic.
      if (!rst) begin
         if (do_push)      mem[push_idx] <= push_data;
         else if (do_swap) mem[top_idx]  <= push_data;
      end
   end

   // Occupancy counter with registered full/empty and the sticky error flag.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
         error <= 1'b0;
      end else begin
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
         empty <= (count_next == '0);
         if (err_now) error <= 1'b1;
      end
   end

endmodule

// File: rtl/flags_unit.sv
// flags_unit: derives ZERO/SIGN/CARRY/OVERFLOW from each ALU result into an
// 8-bit flags register that feeds decision_unit. Register source priority per
// cycle is rst > flags_write > pop > alu_valid; the low nibble is always zero.
// Optional feature macro: FLAGS_SHADOW_STACK_EN builds the flags_stack shadow
// LIFO; without it push/pop are ignored and the stack status outputs are tied
// to full=0, empty=1, error=0.
module flags_unit
   import tau_pkg::*;
#(
   parameter int WORD_SIZE   = 16,
   parameter int STACK_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alu_valid,
   input  logic [1:0]             alu_class,
   input  logic [WORD_SIZE-1:0]   operand_a,
   input  logic [WORD_SIZE-1:0]   operand_b,
   input  logic [WORD_SIZE-1:0]   result,
   input  logic                   carry_out,
   input  logic [3:0]             update_mask,
   input  logic                   flags_write,
   input  logic [FLAGS_WIDTH-1:0] flags_write_data,
   input  logic                   push,
   input  logic                   pop,
   output logic [FLAGS_WIDTH-1:0] flags,
   output logic                   stack_full,
   output logic                   stack_empty,
   output logic                   stack_error
);

   localparam int MSB = WORD_SIZE - 1;

   alu_class_e                  cls;
   logic [FLAGS_WIDTH-1:0]      flags_q;
   logic [FLAGS_WIDTH-1:0]      alu_flags;
   logic [FLAGS_WIDTH-1:0]      flags_next;
   logic [FLAG_STORED_BITS-1:0] stack_top;
   logic                        pop_taken;
   logic                        stack_pop;
   logic                        z_bit;
   logic                        s_bit;
   logic                        c_bit;
   logic                        o_bit;
   logic                        unused_low_bits;

   assign cls   = alu_class_e'(alu_class);
   assign flags = flags_q;

   // Only operand sign bits matter, and the low nibble of a direct load is dropped.
   assign unused_low_bits = ^{operand_a[MSB-1:0], operand_b[MSB-1:0], flags_write_data[3:0]};

   // A direct flags load outranks pop, so the stack is left untouched that cycle.
   assign stack_pop = pop && !flags_write;

   // Derive the four raw flags from the ALU result and merge them through the mask.
   always_comb begin
      z_bit = (result == '0);
      s_bit = result[MSB];
      c_bit = 1'b0;
      o_bit = 1'b0;
      case (cls)
         ALU_ADD: begin
            c_bit = carry_out;
            o_bit = (operand_a[MSB] == operand_b[MSB]) && (result[MSB] != operand_a[MSB]);
         end
         ALU_SUB: begin
            c_bit = carry_out;
            o_bit = (operand_a[MSB] != operand_b[MSB]) && (result[MSB] != operand_a[MSB]);
         end
         ALU_SHIFT: c_bit = carry_out;
         default:   c_bit = 1'b0;
      endcase

      alu_flags = flags_q;
      if (update_mask[3]) alu_flags[FLAG_ZERO]     = z_bit;
      if (update_mask[2]) alu_flags[FLAG_SIGN]     = s_bit;
      if (update_mask[1]) alu_flags[FLAG_CARRY]    = c_bit;
      if (update_mask[0]) alu_flags[FLAG_OVERFLOW] = o_bit;
   end

   // Select the next flags value by source priority.
   always_comb begin
      flags_next = flags_q;
      if (flags_write)    flags_next = {flags_write_data[7:4], 4'b0000};
      else if (pop_taken) flags_next = {stack_top, 4'b0000};
      else if (alu_valid) flags_next = alu_flags;
   end

   // Flags register.
   always_ff @(posedge clk) begin
      if (rst) flags_q <= '0;
      else     flags_q <= flags_next;
   end

`ifdef FLAGS_SHADOW_STACK_EN
   // The stack always saves the pre-update flags, so a same-cycle ALU write
   // still lands in the register while the old value goes onto the stack.
   flags_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (FLAG_STORED_BITS)
   ) u_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (stack_pop),
      .push_data (flags_q[7:4]),
      .top_data  (stack_top),
      .pop_taken (pop_taken),
      .full      (stack_full),
      .empty     (stack_empty),
      .error     (stack_error)
   );
`else
   logic unused_stack_ctrl;

   assign unused_stack_ctrl = ^{push, pop, stack_pop};
   assign stack_top         = '0;
   assign pop_taken         = 1'b0;
   assign stack_full        = 1'b0;
   assign stack_empty       = 1'b1;
   assign stack_error       = 1'b0;
`endif

endmodule

// File: tb/tb_flags_unit.sv
// Self-checking bench for flags_unit: a table of single-cycle vectors for flag
// derivation and source priority, then hand-written multi-cycle sequences for
// the shadow stack (or for its absence when FLAGS_SHADOW_STACK_EN is undefined).
module tb_flags_unit;
   import tau_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [1:0]  alu_class;
   logic [15:0] operand_a;
   logic [15:0] operand_b;
   logic [15:0] result;
   logic        carry_out;
   logic [3:0]  update_mask;
   logic        flags_write;
   logic [7:0]  flags_write_data;
   logic        push;
   logic        pop;
   logic [7:0]  flags;
   logic        stack_full;
   logic        stack_empty;
   logic        stack_error;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [1:0]  cls;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic        c;
      logic [3:0]  mask;
      logic        fw;
      logic [7:0]  fwd;
      logic        push;
      logic        pop;
      logic [7:0]  exp_flags;
      logic        exp_full;
      logic        exp_empty;
      logic        exp_err;
   } vec_t;

   vec_t tbl [16];

   always #5 clk = ~clk;

   flags_unit #(
      .WORD_SIZE   (16),
      .STACK_DEPTH (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .alu_valid        (alu_valid),
      .alu_class        (alu_class),
      .operand_a        (operand_a),
      .operand_b        (operand_b),
      .result           (result),
      .carry_out        (carry_out),
      .update_mask      (update_mask),
      .flags_write      (flags_write),
      .flags_write_data (flags_write_data),
      .push             (push),
      .pop              (pop),
      .flags            (flags),
      .stack_full       (stack_full),
      .stack_empty      (stack_empty),
      .stack_error      (stack_error)
   );

   function automatic vec_t mk(
      input logic rst_v, input logic vld, input logic [1:0] cls,
      input logic [15:0] a, input logic [15:0] b, input logic [15:0] r,
      input logic c, input logic [3:0] mask, input logic fw, input logic [7:0] fwd,
      input logic ps, input logic pp,
      input logic [7:0] ef, input logic efull, input logic eempty, input logic eerr);
      vec_t v;
      v.rst = rst_v; v.vld = vld; v.cls = cls; v.a = a; v.b = b; v.r = r;
      v.c = c; v.mask = mask; v.fw = fw; v.fwd = fwd; v.push = ps; v.pop = pp;
      v.exp_flags = ef; v.exp_full = efull; v.exp_empty = eempty; v.exp_err = eerr;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   // Drive one vector on the falling edge, compare just after the rising edge.
   task automatic run(input vec_t v, input string name);
      @(negedge clk);
      rst              = v.rst;
      alu_valid        = v.vld;
      alu_class        = v.cls;
      operand_a        = v.a;
      operand_b        = v.b;
      result           = v.r;
      carry_out        = v.c;
      update_mask      = v.mask;
      flags_write      = v.fw;
      flags_write_data = v.fwd;
      push             = v.push;
      pop              = v.pop;
      @(posedge clk);
      #1;
      check({name, "/flags"}, flags, v.exp_flags);
      check({name, "/full"},  {7'b0, stack_full},  {7'b0, v.exp_full});
      check({name, "/empty"}, {7'b0, stack_empty}, {7'b0, v.exp_empty});
      check({name, "/error"}, {7'b0, stack_error}, {7'b0, v.exp_err});
   endtask

   initial begin
      rst = 1'b1; alu_valid = 1'b0; alu_class = 2'd0; operand_a = '0; operand_b = '0;
      result = '0; carry_out = 1'b0; update_mask = '0; flags_write = 1'b0;
      flags_write_data = '0; push = 1'b0; pop = 1'b0;

      //               rst vld cls        a        b        r        c  mask  fw fwd    ps pp  flags  fu em er
      tbl[0]  = mk(1, 0, ALU_ADD,   16'h0000,16'h0000,16'h0000,0, 4'h0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
      tbl[1]  = mk(0, 1, ALU_ADD,   16'h7FFF,16'h0001,16'h8000,0, 4'hF, 0, 8'h00, 0, 0, 8'h50, 0, 1, 0);
      tbl[2]  = mk(0, 1, ALU_SUB,   16'h0005,16'h0005,16'h0000,0, 4'hF, 0, 8'h00, 0, 0, 8'h80, 0, 1, 0);
      tbl[3]  = mk(0, 1, ALU_SUB,   16'h0003,16'h0005,16'hFFFE,1, 4'hF, 0, 8'h00, 0, 0, 8'h60, 0, 1, 0);
      tbl[4]  = mk(0, 1, ALU_LOGIC, 16'h00F0,16'h0F00,16'h0000,1, 4'h8, 0, 8'h00, 0, 0, 8'hE0, 0, 1, 0);
      tbl[5]  = mk(0, 0, ALU_ADD,   16'h0001,16'h0001,16'h0002,0, 4'hF, 0, 8'h00, 0, 0, 8'hE0, 0, 1, 0);
      tbl[6]  = mk(0, 1, ALU_LOGIC, 16'h8001,16'hFFFF,16'h8001,1, 4'hF, 0, 8'h00, 0, 0, 8'h40, 0, 1, 0);
      tbl[7]  = mk(0, 1, ALU_SHIFT, 16'h8000,16'h0001,16'h0000,1, 4'hF, 0, 8'h00, 0, 0, 8'hA0, 0, 1, 0);
      tbl[8]  = mk(0, 1, ALU_SUB,   16'h8000,16'h0001,16'h7FFF,0, 4'hF, 0, 8'h00, 0, 0, 8'h10, 0, 1, 0);
      tbl[9]  = mk(0, 1, ALU_ADD,   16'h8000,16'h8000,16'h0000,1, 4'hF, 0, 8'h00, 0, 0, 8'hB0, 0, 1, 0);
      tbl[10] = mk(0, 0, ALU_ADD,   16'h0000,16'h0000,16'h0000,0, 4'h0, 1, 8'h5A, 0, 0, 8'h50, 0, 1, 0);
      tbl[11] = mk(0, 1, ALU_ADD,   16'h0000,16'h0000,16'h0000,1, 4'hF, 1, 8'hFF, 0, 0, 8'hF0, 0, 1, 0);
      tbl[12] = mk(0, 1, ALU_ADD,   16'h0001,16'h0001,16'h0002,0, 4'h0, 0, 8'h00, 0, 0, 8'hF0, 0, 1, 0);
      tbl[13] = mk(0, 1, ALU_ADD,   16'h0000,16'h0001,16'h0001,0, 4'h4, 0, 8'h00, 0, 0, 8'hB0, 0, 1, 0);
      tbl[14] = mk(0, 1, ALU_ADD,   16'h0000,16'h0001,16'h0001,0, 4'h2, 0, 8'h00, 0, 0, 8'h90, 0, 1, 0);
      tbl[15] = mk(1, 1, ALU_ADD,   16'h0000,16'h0000,16'h0000,1, 4'hF, 1, 8'hFF, 0, 0, 8'h00, 0, 1, 0);

      for (int i = 0; i < 16; i++) run(tbl[i], $sformatf("vec%0d", i));

`ifdef FLAGS_SHADOW_STACK_EN
      // Push, ALU update, pop restores, second pop is an error.
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,1,8'h80,0,0, 8'h80,0,1,0), "a_load");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,1,0, 8'h80,0,0,0), "a_push");
      run(mk(0,1,ALU_SUB,16'h0003,16'h0005,16'hFFFE,1,4'hF,0,8'h00,0,0, 8'h60,0,0,0), "a_alu");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,1, 8'h80,0,1,0), "a_pop");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,1, 8'h80,0,1,1), "a_pop_empty");

      // Push saves the pre-update value while the same-cycle ALU result lands.
      run(mk(1,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,0, 8'h00,0,1,0), "b_rst");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,1,8'h40,0,0, 8'h40,0,1,0), "b_load");
      run(mk(0,1,ALU_SUB,16'h0005,16'h0005,16'h0000,0,4'hF,0,8'h00,1,0, 8'h80,0,0,0), "b_push_alu");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,1, 8'h40,0,1,0), "b_pop");

      // Fill to depth, overflow push, swap, drain in LIFO order, reset.
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,1,8'h10,0,0, 8'h10,0,1,0), "c_load");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,1,8'h20,1,0, 8'h20,0,0,0), "c_push1");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,1,8'h30,1,0, 8'h30,0,0,0), "c_push2");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,1,8'h40,1,0, 8'h40,0,0,0), "c_push3");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,1,0, 8'h40,1,0,0), "c_push4");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,1,0, 8'h40,1,0,1), "c_push_full");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,1,8'h70,0,0, 8'h70,1,0,1), "c_load70");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,1,1, 8'h40,1,0,1), "c_swap");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,1, 8'h70,0,0,1), "c_pop4");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,1, 8'h30,0,0,1), "c_pop3");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,1, 8'h20,0,0,1), "c_pop2");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,1, 8'h10,0,1,1), "c_pop1");
      run(mk(1,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,0, 8'h00,0,1,0), "c_rst");

      // Reset discards stacked entries.
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,1,0, 8'h00,0,0,0), "d_push");
      run(mk(1,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,0, 8'h00,0,1,0), "d_rst");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,1, 8'h00,0,1,1), "d_pop");

      // flags_write outranks pop and ALU; the stack keeps its entry.
      run(mk(1,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,0, 8'h00,0,1,0), "e_rst");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,1,8'h30,0,0, 8'h30,0,1,0), "e_load");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,1,0, 8'h30,0,0,0), "e_push");
      run(mk(0,1,ALU_ADD,0,0,0,1,4'hF,1,8'hFF,0,1, 8'hF0,0,0,0), "e_write_prio");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,1, 8'h30,0,1,0), "e_pop");

      // Pop on empty: ignored, but the ALU update still applies.
      run(mk(0,1,ALU_ADD,16'h7FFF,16'h0001,16'h8000,0,4'hF,0,8'h00,0,1, 8'h50,0,1,1), "f_pop_alu");

      // Swap on an empty stack is an error pop with no change.
      run(mk(1,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,0, 8'h00,0,1,0), "g_rst");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,1,8'hA0,0,0, 8'hA0,0,1,0), "g_load");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,1,1, 8'hA0,0,1,1), "g_swap_empty");
`else
      // Without the shadow stack, push/pop have no effect and status is constant.
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,1,8'h80,0,0, 8'h80,0,1,0), "n_load");
      for (int i = 0; i < 5; i++)
         run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,1,0, 8'h80,0,1,0), $sformatf("n_push%0d", i));
      run(mk(0,1,ALU_SUB,16'h0003,16'h0005,16'hFFFE,1,4'hF,0,8'h00,0,0, 8'h60,0,1,0), "n_alu");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,0,1, 8'h60,0,1,0), "n_pop");
      run(mk(0,1,ALU_SUB,16'h0005,16'h0005,16'h0000,0,4'hF,0,8'h00,0,1, 8'h80,0,1,0), "n_pop_alu");
      run(mk(0,0,ALU_ADD,0,0,0,0,4'h0,0,8'h00,1,1, 8'h80,0,1,0), "n_swap");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/flags_unit.md
# flags_unit

Processor status-flag producer: derives ZERO/SIGN/CARRY/OVERFLOW from each ALU result, holds them in an 8-bit flags register, and drives `flags` straight into `decision_unit` for conditional-jump resolution. A small LIFO shadow stack saves and restores flags across call/interrupt entry and exit. The unit sits between the ALU writeback path and the branch logic.

## Interface
- `WORD_SIZE`, 16, ALU operand/result width
- `STACK_DEPTH`, 4, shadow-stack entries (≥1)

- `clk` in 1 — clock
- `rst` in 1 — synchronous, active-high reset
- `alu_valid` in 1 — ALU result valid this cycle
- `alu_class` in 2 — ADD=0, SUB=1, LOGIC=2, SHIFT=3
- `operand_a` in WORD_SIZE — ALU operand A
- `operand_b` in WORD_SIZE — ALU operand B
- `result` in WORD_SIZE — ALU result
- `carry_out` in 1 — ALU carry (ADD), borrow (SUB), last bit shifted out (SHIFT)
- `update_mask` in 4 — {Z,S,C,O} per-flag update enables
- `flags_write` in 1 — direct load of flags register
- `flags_write_data` in 8 — data for direct load
- `push` in 1 — save current flags to shadow stack
- `pop` in 1 — restore flags from shadow stack
- `flags` out 8 — bit7 ZERO, bit6 SIGN, bit5 CARRY, bit4 OVERFLOW, bits3:0 always 0
- `stack_full` out 1 — stack holds STACK_DEPTH entries
- `stack_empty` out 1 — stack holds 0 entries
- `stack_error` out 1 — sticky: push-when-full or pop-when-empty seen

## Operation
- Flag derivation (only for flags whose mask bit is 1; others hold):
  - Z = (result == 0); S = result[MSB]
  - C: ADD/SUB/SHIFT = carry_out; LOGIC = 0
  - O: ADD = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]); SUB = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]); LOGIC/SHIFT = 0
- Flags-register source priority per cycle: `rst` > `flags_write` > `pop` > `alu_valid`. `flags_write_data[3:0]` are discarded (stored as 0).
- Push stores the flags value present *before* this cycle's update; an ALU update in the same cycle still applies to the register.
- Push + pop in the same cycle: swap — top entry replaced by current flags, register loads old top, count unchanged. On an empty stack: treated as an error pop, no change.
- Push when full: ignored, `stack_error` ← 1. Pop when empty: ignored, register unchanged (lower-priority ALU update still applies), `stack_error` ← 1.
- `stack_error` clears only on `rst`.

## Timing
- All outputs registered; `flags` reflects an update one cycle after the `alu_valid`/`flags_write`/`pop` edge.
- Reset values: `flags`=0x00, `stack_full`=0, `stack_empty`=1, `stack_error`=0, stack count 0 (contents don't-care).
- `rst` mid-sequence discards all stacked entries in the same edge.
- `stack_full`/`stack_empty` update on the same edge as the count.

## Configuration
- `FLAGS_SHADOW_STACK_EN` defined: shadow stack built as above.
- Not defined: no stack storage. `push`/`pop` ignored; `stack_full`=0, `stack_empty`=1, `stack_error`=0 constantly. Flag derivation unchanged.

## Structure
- Shared package `tau_pkg`: flag bit positions (ZERO=7, SIGN=6, CARRY=5, OVERFLOW=4), `alu_class` enum, FLAGS_WIDTH=8. `decision_unit` benches use the same positions.
- Sub-module `flags_stack`: parameterised LIFO (push/pop/swap, full/empty, count). Instantiated only under `FLAGS_SHADOW_STACK_EN`.

## Test plan
- ADD 0x7FFF+0x0001, result 0x8000, carry_out 0, mask 1111 → next cycle `flags`=0x50.
- SUB 0x0005−0x0005, result 0x0000, carry_out 0 → 0x80; then SUB 0x0003−0x0005, result 0xFFFE, carry_out 1 → 0x60.
- Flags 0x60, LOGIC result 0x0000, mask 1000 → 0xE0 (C held despite LOGIC).
- Flags 0x80, push; ADD → 0x60; pop → 0x80, `stack_empty`=1; second pop → flags 0x80, `stack_error`=1.
- STACK_DEPTH=4: four pushes → `stack_full`=1; fifth push → `stack_error`=1, count stays 4; then `rst` → flags 0x00, empty=1, error=0.
- Same cycle `flags_write`=0xFF, `alu_valid`, `pop` with non-empty stack → `flags`=0xF0, stack count unchanged.
